// File: rtl/t5_dmem_pkg.sv
// rtl/t5_dmem_pkg.sv - shared width, FSM encodings and byte-select legality for t5_dmem
package t5_dmem_pkg;

  localparam int T5_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Naturally aligned byte, half-word and word selects
  localparam logic [3:0] SEL_B0 = 4'h1;
  localparam logic [3:0] SEL_B1 = 4'h2;
  localparam logic [3:0] SEL_B2 = 4'h4;
  localparam logic [3:0] SEL_B3 = 4'h8;
  localparam logic [3:0] SEL_H0 = 4'h3;
  localparam logic [3:0] SEL_H1 = 4'hC;
  localparam logic [3:0] SEL_W  = 4'hF;

  function automatic logic sel_is_legal(input logic [3:0] sel);
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_H0, SEL_H1, SEL_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/t5_dmem_if.sv
// rtl/t5_dmem_if.sv - CPU data-bus (dwb) signal bundle with CPU-side and memory-side views
interface t5_dmem_if
  import t5_dmem_pkg::*;
#(
  parameter int XLEN = T5_XLEN
) ();

  logic            stb;
  logic            wre;
  logic [3:0]      sel;
  logic [XLEN-3:0] adr;
  logic [XLEN-1:0] dto;
  logic [XLEN-1:0] dti;
  logic            ack;
  logic            err;

  modport master (
    output stb, wre, sel, adr, dto,
    input  dti, ack, err
  );

  modport slave (
    input  stb, wre, sel, adr, dto,
    output dti, ack, err
  );

endinterface

// File: rtl/t5_dmem_ram.sv
// rtl/t5_dmem_ram.sv - four byte-wide single-port banks, per-lane write enable, registered read
module t5_dmem_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          ena,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  // One bank per lane keeps each array a plain 8-bit RAM for block-RAM mapping
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (ena && we[i]) begin
        mem[addr] <= wdata[8*i +: 8];
      end
      if (ena && re) begin
        q <= mem[addr];
      end
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/t5_dmem.sv
// rtl/t5_dmem.sv - t5_cpu data-bus RAM responder with programmable wait states
// Optional: define T5_DMEM_ERR_EN to answer illegal byte selects with dwb_err instead of ack.
module t5_dmem
  import t5_dmem_pkg::*;
#(
  parameter int XLEN = T5_XLEN,
  parameter int AW   = 14,
  parameter int WAIT = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sys_ena,
  t5_dmem_if.slave   dwb
);

  localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            commit;
  logic            legal;
  logic            err_q;
  logic            rd_seen_q;
  logic [3:0]      ram_we;
  logic            ram_re;
  logic [XLEN-1:0] ram_q;
  logic            unused_adr;

`ifdef T5_DMEM_ERR_EN
  assign legal = sel_is_legal(dwb.sel);
`else
  assign legal = 1'b1;
`endif

  assign unused_adr = ^dwb.adr[XLEN-3:AW];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      rd_seen_q <= 1'b0;
    end else if (sys_ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q <= !legal;
        if (!dwb.wre && legal) begin
          rd_seen_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dwb.stb) begin
          if (WAIT == 0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_M1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Dropping stb while waiting abandons the request with no side effects
        if (!dwb.stb) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dwb.ack = (state_q == ST_RESP) && !err_q;
`ifdef T5_DMEM_ERR_EN
    dwb.err = (state_q == ST_RESP) && err_q;
`else
    dwb.err = 1'b0;
`endif
  end

  assign ram_we = (commit && dwb.wre && legal) ? dwb.sel : 4'b0000;
  assign ram_re = commit && !dwb.wre && legal;

  t5_dmem_ram #(
    .AW(AW)
  ) u_ram (
    .clk   (sys_clk),
    .ena   (sys_ena),
    .addr  (dwb.adr[AW-1:0]),
    .we    (ram_we),
    .re    (ram_re),
    .wdata (dwb.dto),
    .rdata (ram_q)
  );

  // The RAM output register is not reset; masking until the first read gives dti=0 out of reset
  assign dwb.dti = rd_seen_q ? ram_q : '0;

endmodule

// File: tb/tb_t5_dmem.sv
// tb/tb_t5_dmem.sv - table-driven scoreboard bench for t5_dmem at WAIT=0 and WAIT=3
module tb_t5_dmem;

  logic sys_clk;
  logic sys_rst_n;
  logic sys_ena;

  t5_dmem_if #(.XLEN(32)) if0 ();
  t5_dmem_if #(.XLEN(32)) if3 ();

  t5_dmem #(.XLEN(32), .AW(14), .WAIT(0)) dut0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sys_ena   (sys_ena),
    .dwb       (if0)
  );

  t5_dmem #(.XLEN(32), .AW(14), .WAIT(3)) dut3 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sys_ena   (sys_ena),
    .dwb       (if3)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          wre;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] dto;
    logic [31:0] dti;
  } vec_t;

  typedef struct {
    logic [31:0] dti;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vt[13];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input int d, input bit stb, input bit wre, input logic [3:0] sel,
                       input logic [29:0] adr, input logic [31:0] dto);
    if (d == 0) begin
      if0.stb = stb; if0.wre = wre; if0.sel = sel; if0.adr = adr; if0.dto = dto;
    end else begin
      if3.stb = stb; if3.wre = wre; if3.sel = sel; if3.adr = adr; if3.dto = dto;
    end
  endtask

  task automatic set_stb(input int d, input bit v);
    if (d == 0) if0.stb = v;
    else if3.stb = v;
  endtask

  function automatic logic get_ack(input int d);
    return (d == 0) ? if0.ack : if3.ack;
  endfunction

  function automatic logic get_err(input int d);
    return (d == 0) ? if0.err : if3.err;
  endfunction

  function automatic logic [31:0] get_dti(input int d);
    return (d == 0) ? if0.dti : if3.dti;
  endfunction

  // lat counts negedges from the cycle stb rises (that cycle is 0)
  task automatic xact(input int d, input bit wre, input logic [3:0] sel, input logic [29:0] adr,
                      input logic [31:0] dto, input logic [31:0] exp_dti, input bit exp_err,
                      input int exp_lat, input int abort_at, input int freeze_at, input string name);
    bit   got;
    int   limit;
    exp_t e;
    got   = 1'b0;
    limit = (abort_at >= 0) ? 12 : 40;
    @(posedge sys_clk); #1;
    drive(d, 1'b1, wre, sel, adr, dto);
    if (abort_at < 0) sb.push_back('{dti: exp_dti, err: exp_err, lat: exp_lat});
    for (int lat = 0; lat < limit && !got; lat++) begin
      @(negedge sys_clk);
      if (get_ack(d) || get_err(d)) begin
        got = 1'b1;
        set_stb(d, 1'b0);
        if (sb.size() == 0) begin
          check({name, " unexpected resp"}, 32'(get_ack(d) | get_err(d)), 32'd0);
        end else begin
          e = sb.pop_front();
          check({name, " latency"}, 32'(lat), 32'(e.lat));
          check({name, " ack"}, 32'(get_ack(d)), 32'(!e.err));
          check({name, " err"}, 32'(get_err(d)), 32'(e.err));
          check({name, " dti"}, get_dti(d), e.dti);
        end
        @(negedge sys_clk);
        check({name, " one-cycle"}, 32'(get_ack(d) | get_err(d)), 32'd0);
      end else begin
        if (lat == abort_at) set_stb(d, 1'b0);
        if (lat == freeze_at) sys_ena = 1'b0;
        if (freeze_at >= 0 && lat == freeze_at + 5) sys_ena = 1'b1;
      end
    end
    if (abort_at >= 0) begin
      check({name, " no resp"}, 32'(got), 32'd0);
    end else begin
      check({name, " resp seen"}, 32'(got), 32'd1);
      if (!got) begin
        sb.delete();
        set_stb(d, 1'b0);
        sys_ena = 1'b1;
      end
    end
  endtask

  initial begin
    int   acks;
    exp_t e;
    n_pass  = 0;
    n_total = 0;

    vt[0]  = '{1'b1, 4'hF, 30'h0010, 32'hDEADBEEF, 32'h00000000};
    vt[1]  = '{1'b0, 4'hF, 30'h0010, 32'h00000000, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 4'hF, 30'h0020, 32'h11223344, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 4'h2, 30'h0020, 32'h0000AA00, 32'hDEADBEEF};
    vt[4]  = '{1'b0, 4'hF, 30'h0020, 32'h00000000, 32'h1122AA44};
    vt[5]  = '{1'b1, 4'hC, 30'h0020, 32'h55660000, 32'h1122AA44};
    vt[6]  = '{1'b0, 4'h1, 30'h0020, 32'h00000000, 32'h5566AA44};
    vt[7]  = '{1'b1, 4'hF, 30'h4010, 32'hCAFEF00D, 32'h5566AA44};
    vt[8]  = '{1'b0, 4'hF, 30'h0010, 32'h00000000, 32'hCAFEF00D};
    vt[9]  = '{1'b1, 4'hF, 30'h3FFF, 32'h0BADF00D, 32'hCAFEF00D};
    vt[10] = '{1'b0, 4'hF, 30'h7FFF, 32'h00000000, 32'h0BADF00D};
    vt[11] = '{1'b1, 4'h1, 30'h0010, 32'h000000EE, 32'h0BADF00D};
    vt[12] = '{1'b0, 4'h3, 30'h4010, 32'h00000000, 32'hCAFEF0EE};

    sys_rst_n = 1'b0;
    sys_ena   = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    drive(3, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0);
    repeat (2) @(negedge sys_clk);
    check("rst ack0", 32'(if0.ack), 32'd0);
    check("rst err0", 32'(if0.err), 32'd0);
    check("rst dti0", if0.dti, 32'd0);
    check("rst ack3", 32'(if3.ack), 32'd0);
    check("rst err3", 32'(if3.err), 32'd0);
    check("rst dti3", if3.dti, 32'd0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      xact(0, vt[i].wre, vt[i].sel, vt[i].adr, vt[i].dto, vt[i].dti, 1'b0, 1, -1, -1,
           $sformatf("v%0d", i));
    end

    // WAIT=3 latency, abort in WAIT, clock-enable freeze
    xact(3, 1'b1, 4'hF, 30'h0040, 32'h12345678, 32'h00000000, 1'b0, 4, -1, -1, "w3 wr");
    xact(3, 1'b0, 4'hF, 30'h0040, 32'h00000000, 32'h12345678, 1'b0, 4, -1, -1, "w3 rd");
    xact(3, 1'b1, 4'hF, 30'h0040, 32'hFFFFFFFF, 32'h12345678, 1'b0, 4, 1, -1, "w3 abort");
    xact(3, 1'b0, 4'hF, 30'h0040, 32'h00000000, 32'h12345678, 1'b0, 4, -1, -1, "w3 rd after abort");
    xact(3, 1'b0, 4'hF, 30'h0040, 32'h00000000, 32'h12345678, 1'b0, 9, -1, 1, "w3 ena freeze");

    // Back-to-back reads with stb held high
    acks = 0;
    @(posedge sys_clk); #1;
    drive(0, 1'b1, 1'b0, 4'hF, 30'h0020, 32'h0);
    for (int i = 0; i < 4; i++) sb.push_back('{dti: 32'h5566AA44, err: 1'b0, lat: 0});
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      check($sformatf("b2b ack c%0d", i), 32'(if0.ack), 32'(i % 2));
      if (if0.ack && sb.size() > 0) begin
        acks++;
        e = sb.pop_front();
        check($sformatf("b2b dti c%0d", i), if0.dti, e.dti);
      end
    end
    if0.stb = 1'b0;
    check("b2b ack count", 32'(acks), 32'd4);
    sb.delete();
    @(negedge sys_clk);

`ifdef T5_DMEM_ERR_EN
    xact(0, 1'b1, 4'h5, 30'h0020, 32'h99999999, 32'h5566AA44, 1'b1, 1, -1, -1, "sel5 wr");
    xact(0, 1'b0, 4'hF, 30'h0020, 32'h00000000, 32'h5566AA44, 1'b0, 1, -1, -1, "sel5 rd");
`else
    xact(0, 1'b1, 4'h5, 30'h0020, 32'h99999999, 32'h5566AA44, 1'b0, 1, -1, -1, "sel5 wr");
    xact(0, 1'b0, 4'hF, 30'h0020, 32'h00000000, 32'h5599AA99, 1'b0, 1, -1, -1, "sel5 rd");
`endif

    // Asynchronous reset while dut3 is in WAIT
    @(posedge sys_clk); #1;
    drive(3, 1'b1, 1'b0, 4'hF, 30'h0040, 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("arst ack3", 32'(if3.ack), 32'd0);
    check("arst err3", 32'(if3.err), 32'd0);
    check("arst dti3", if3.dti, 32'd0);
    check("arst dti0", if0.dti, 32'd0);
    if3.stb = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    xact(3, 1'b0, 4'hF, 30'h0040, 32'h00000000, 32'h12345678, 1'b0, 4, -1, -1, "post-rst rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
